// File: rtl/passcode_checker.sv
// Keypad front end for the door lock: buffers BCD digits, checks or programs the
// passcode depending on the lock FSM state, and locks the keypad out after repeated failures.
module passcode_checker #(
    parameter int          DIGITS       = 6,
    parameter int          DIGIT_W      = 4,
    parameter logic [23:0] DEFAULT_CODE = 24'h123456,
    parameter int          MAX_FAIL     = 3,
    parameter int          LOCK_CYCLES  = 1000
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              key_valid_i,
    input  logic [DIGIT_W-1:0]                key_digit_i,
    input  logic                              key_ent_i,
    input  logic                              key_clr_i,
    input  logic [1:0]                        state_i,
    output logic                              corr_o,
    output logic                              set_o,
    output logic                              err_o,
    output logic                              lockout_o,
    output logic [$clog2(DIGITS+1)-1:0]       digit_cnt_o
);

    localparam int CODE_W = DIGITS * DIGIT_W;
    localparam int CNT_W  = $clog2(DIGITS + 1);
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_ENT  = 2'b01;
    localparam logic [1:0] ST_OPEN = 2'b11;
    localparam logic [1:0] ST_SET  = 2'b10;

    localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(DIGITS);
    localparam logic [FAIL_W-1:0]  FAIL_MAX   = FAIL_W'(MAX_FAIL);
    localparam logic [FAIL_W-1:0]  FAIL_LAST  = FAIL_W'(MAX_FAIL - 1);
    localparam logic [LOCK_W-1:0]  LOCK_LOAD  = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [DIGIT_W-1:0] DIGIT_MAX  = DIGIT_W'(9);

    typedef enum logic {
        READY  = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

    lock_state_t         state;
    lock_state_t         next_state;

    logic [CODE_W-1:0]   code_reg;
    logic [CODE_W-1:0]   buffer;
    logic [CNT_W-1:0]    count;
    logic [FAIL_W-1:0]   fail_cnt;
    logic [LOCK_W-1:0]   lock_cnt;
    logic [1:0]          last_state;
    logic                corr_q;
    logic                set_q;
    logic                err_q;

    logic                state_changed;
    logic                keys_enabled;
    logic                do_clr;
    logic                do_ent;
    logic                do_digit;
    logic                buffer_full;
    logic                code_match;
    logic                code_ok;
    logic                code_bad;
    logic                set_ok;
    logic                set_bad;
    logic                lock_trigger;
    logic                lock_done;

    // Keys are only honoured while unlocked, in a keypad-facing lock state, and not in the
    // cycle where that state has just changed (that cycle flushes any partial entry instead).
    always_comb begin
        state_changed = (state_i != last_state);
        keys_enabled  = (state == READY) && !state_changed &&
                        ((state_i == ST_ENT) || (state_i == ST_SET));
        do_clr        = keys_enabled && key_clr_i;
        do_ent        = keys_enabled && !key_clr_i && key_ent_i;
        buffer_full   = (count == CNT_FULL);
        do_digit      = keys_enabled && !key_clr_i && !key_ent_i && key_valid_i &&
                        (key_digit_i <= DIGIT_MAX) && !buffer_full;
        code_match    = buffer_full && (buffer == code_reg);
        code_ok       = do_ent && (state_i == ST_ENT) && code_match;
        code_bad      = do_ent && (state_i == ST_ENT) && !code_match;
        set_ok        = do_ent && (state_i == ST_SET) && buffer_full;
        set_bad       = do_ent && (state_i == ST_SET) && !buffer_full;
        lock_trigger  = code_bad && (fail_cnt >= FAIL_LAST);
        lock_done     = (state == LOCKED) && (lock_cnt == '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= READY;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            READY: begin
                if (lock_trigger) begin
                    next_state = LOCKED;
                end
            end
            LOCKED: begin
                if (lock_done) begin
                    next_state = READY;
                end
            end
            default: begin
                next_state = READY;
            end
        endcase
    end

    always_comb begin
        lockout_o   = (state == LOCKED);
        corr_o      = corr_q;
        set_o       = set_q;
        err_o       = err_q;
        digit_cnt_o = count;
    end

    // Result pulses are registered so they appear the cycle after the enter key is sampled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            corr_q     <= 1'b0;
            set_q      <= 1'b0;
            err_q      <= 1'b0;
            last_state <= ST_IDLE;
        end else begin
            corr_q     <= code_ok;
            set_q      <= set_ok;
            err_q      <= code_bad || set_bad;
            last_state <= state_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buffer <= '0;
            count  <= '0;
        end else if (!keys_enabled || do_clr || do_ent) begin
            buffer <= '0;
            count  <= '0;
        end else if (do_digit) begin
            buffer <= {buffer[CODE_W-DIGIT_W-1:0], key_digit_i};
            count  <= count + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            code_reg <= DEFAULT_CODE[CODE_W-1:0];
        end else if (set_ok) begin
            code_reg <= buffer;
        end
    end

    // Failures only accumulate from verification attempts; programming is already authenticated.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fail_cnt <= '0;
        end else if (state == LOCKED) begin
            if (lock_done) begin
                fail_cnt <= '0;
            end
        end else if (code_ok) begin
            fail_cnt <= '0;
        end else if (code_bad && (fail_cnt != FAIL_MAX)) begin
            fail_cnt <= fail_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_cnt <= '0;
        end else if ((state == READY) && lock_trigger) begin
            lock_cnt <= LOCK_LOAD;
        end else if ((state == LOCKED) && (lock_cnt != '0)) begin
            lock_cnt <= lock_cnt - 1'b1;
        end
    end

endmodule
